conv_index_encoder: RTL and testbench
=====================================

# conv_index_encoder

Inverse of the convolution index decoder. Given one flattened input-feature index, it enumerates every (output pixel, kernel position) pair whose receptive field covers that input element. Each pair is emitted as one beat on a valid/ready stream. The block sits on the col2im / gradient-scatter path, where each input element must collect contributions from all output pixels that read it.

## Interface
- K, 3, kernel dimension; kernel positions are K*K, flattened row-major as kidx = k_x*K + k_y.
- N, 2, output dimension; output pixels are N*N, with p = p_x*N + p_y.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_index  in  $clog2(N*N*K*K)  input index on an (N*K)x(N*K) grid, row r = index/(N*K), col c = index%(N*K).
- stride  in  $clog2(K)  stride between output pixels.
- kernel_width  in  $clog2(K)  active kernel extent; positions with k_x or k_y ≥ kernel_width are excluded.
- out_valid  out  1  beat valid.
- out_ready  in  1  beat consumed when out_valid && out_ready.
- out_pixel  out  $clog2(N*N)  output pixel number.
- out_kidx  out  $clog2(K*K)  kernel position index.
- out_hit  out  1  1 = real pair; 0 = "no pairs" terminator.
- out_last  out  1  final beat of the current request.
- out_err  out  1  illegal request (macro-dependent, see Configuration).

## Operation
- States: IDLE, EMIT.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On accept, stride and kernel_width are latched, and an N*N-bit hit mask is registered. Bit p is set iff k_x = r − stride*p_x and k_y = c − stride*p_y both satisfy 0 ≤ k < kernel_width.
  - The per-pixel k_x and k_y are registered alongside the mask.
  - Next state is EMIT.
- Arithmetic: signed, one bit wider than $clog2(N*K)+1, so negative offsets never wrap. At most one kernel position exists per pixel.
- EMIT, mask nonzero:
  - out_pixel = lowest set bit; out_kidx = its k_x*K + k_y; out_hit = 1.
  - out_last = 1 iff exactly one bit remains.
  - On a handshake, that bit is cleared. If it was last, go to IDLE.
- EMIT, mask zero: emit a single beat with out_hit = 0, out_last = 1, out_pixel = 0, out_kidx = 0. Go to IDLE on handshake.
- Beats are issued in ascending pixel order.
- Outputs hold stable while out_valid && !out_ready.
- Reset values (any state, including mid-burst): state IDLE, mask 0, out_valid 0, out_pixel 0, out_kidx 0, out_hit 0, out_last 0, out_err 0, in_ready 1 once rst deasserts. A partially emitted request is discarded.

## Timing
- First beat is valid in the cycle after request acceptance (1-cycle latency).
- Throughput is one beat per cycle under continuous out_ready; a request with h hits occupies max(h,1) EMIT cycles.
- in_ready is 0 throughout EMIT. In the cycle the last beat handshakes, in_ready stays 0; it rises the next cycle. Minimum request spacing is max(h,1)+1 cycles.
- in_valid is ignored outside IDLE; no combinational path from in_* to out_*.

## Configuration
- INDEX_ENCODER_CHECK_EN defined:
  - A request is illegal if in_index ≥ (N*K)², stride = 0, kernel_width = 0, or kernel_width > K.
  - An illegal request is accepted and answered with one beat: out_hit = 0, out_last = 1, out_err = 1.
  - out_err is valid only with out_valid.
- Undefined: no checks; out_err is tied to 0; raw bits are computed as described.

## Structure
- Package conv_index_pkg holds:
  - constants NK = N*K and the index, pixel and kidx widths as functions of K and N;
  - the state enum {IDLE, EMIT}.
- Sub-module pixel_hit_mask is purely combinational. It takes r, c, stride and kernel_width and returns the N*N mask plus per-pixel k_x and k_y.
- The top level holds the FSM, the registers, and the lowest-set-bit priority encoder.

## Test plan
Unless stated otherwise, K=3, N=2, out_ready=1.
- stride=2, kw=3, in_index=14 (r2,c2) -> 4 beats (p,kidx): (0,8), (1,6), (2,2), (3,0); out_last only on the 4th; in_ready returns 1 cycle after.
- stride=2, kw=3, in_index=0 -> single beat (0,0), out_hit=1, out_last=1.
- stride=1, kw=3, in_index=35 -> single beat out_hit=0, out_last=1, out_err=0.
- stride=3, kw=3, in_index=35 with out_ready toggling 0/1 every cycle -> exactly one beat (3,8), held stable while stalled.
- Assert rst during the 2nd beat of the in_index=14 case -> next cycle out_valid=0 and in_ready=1; a fresh request in_index=0 then yields (0,0) correctly.
- With INDEX_ENCODER_CHECK_EN: in_index=36 or stride=0 -> one beat out_hit=0, out_last=1, out_err=1. Without the macro, out_err stays 0.

Source files
------------

// File: rtl/conv_index_encoder_pkg.sv
// Shared geometry constants, state encoding and kernel-index helper for conv_index_encoder.
// Kernel K=3, output N=2; all widths derive from these two values.
package conv_index_pkg;

  localparam int unsigned K      = 3;
  localparam int unsigned N      = 2;
  localparam int unsigned NK     = N * K;
  localparam int unsigned NPIX   = N * N;
  localparam int unsigned IDX_W  = $clog2(N * N * K * K);
  localparam int unsigned PIX_W  = $clog2(N * N);
  localparam int unsigned KIDX_W = $clog2(K * K);
  localparam int unsigned KC_W   = $clog2(K);
  // Signed offset width: one bit wider than $clog2(NK)+1 so r - stride*p never wraps.
  localparam int unsigned SW     = $clog2(NK) + 2;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  typedef logic [KC_W-1:0] kcoord_t;

  function automatic logic [KIDX_W-1:0] kidx_of(input kcoord_t kx, input kcoord_t ky);
    return KIDX_W'(int'(kx) * int'(K) + int'(ky));
  endfunction

endpackage

// File: rtl/conv_index_encoder_hit_mask.sv
// Combinational receptive-field test: for each output pixel, the kernel offset that
// lands on input (r,c) and whether that offset lies inside the active kernel window.
module pixel_hit_mask
  import conv_index_pkg::*;
(
  input  logic [SW-2:0]              r_i,
  input  logic [SW-2:0]              c_i,
  input  logic [KC_W-1:0]            stride_i,
  input  logic [KC_W-1:0]            kernel_width_i,
  output logic [NPIX-1:0]            mask_o,
  output logic [NPIX-1:0][KC_W-1:0]  kx_o,
  output logic [NPIX-1:0][KC_W-1:0]  ky_o
);

  logic signed [SW-1:0] rs;
  logic signed [SW-1:0] cs;
  logic signed [SW-1:0] kws;
  logic signed [SW-1:0] dx_w [NPIX];
  logic signed [SW-1:0] dy_w [NPIX];

  always_comb begin
    rs     = signed'(SW'(r_i));
    cs     = signed'(SW'(c_i));
    kws    = signed'(SW'(kernel_width_i));
    mask_o = '0;
    kx_o   = '0;
    ky_o   = '0;
    for (int unsigned px = 0; px < N; px++) begin
      for (int unsigned py = 0; py < N; py++) begin
        dx_w[px*N+py] = rs - signed'(SW'(stride_i) * SW'(px));
        dy_w[px*N+py] = cs - signed'(SW'(stride_i) * SW'(py));
        mask_o[px*N+py] = (dx_w[px*N+py] >= 0) && (dx_w[px*N+py] < kws) &&
                          (dy_w[px*N+py] >= 0) && (dy_w[px*N+py] < kws);
        // Offsets are only meaningful (and only fit KC_W) where the mask bit is set.
        kx_o[px*N+py] = dx_w[px*N+py][KC_W-1:0];
        ky_o[px*N+py] = dy_w[px*N+py][KC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/conv_index_encoder.sv
// Enumerates every (output pixel, kernel position) pair covering one input index, one beat
// per cycle in ascending pixel order. Optional request checking: INDEX_ENCODER_CHECK_EN.
module conv_index_encoder
  import conv_index_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_index,
  input  logic [KC_W-1:0]   stride,
  input  logic [KC_W-1:0]   kernel_width,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_pixel,
  output logic [KIDX_W-1:0] out_kidx,
  output logic              out_hit,
  output logic              out_last,
  output logic              out_err
);

  state_e                    state_q;
  logic [NPIX-1:0]           mask_q;
  logic [NPIX-1:0]           mask_d;
  logic [NPIX-1:0][KC_W-1:0] kx_q;
  logic [NPIX-1:0][KC_W-1:0] ky_q;
  logic                      err_q;

  logic [SW-2:0]             row_w;
  logic [SW-2:0]             col_w;
  logic [NPIX-1:0]           hit_mask_w;
  logic [NPIX-1:0][KC_W-1:0] hit_kx_w;
  logic [NPIX-1:0][KC_W-1:0] hit_ky_w;
  logic                      illegal_w;

  logic [PIX_W-1:0]          sel_pix;
  logic                      found;
  logic                      last_w;
  logic                      emit_w;

  assign row_w = (SW-1)'(in_index / IDX_W'(NK));
  assign col_w = (SW-1)'(in_index % IDX_W'(NK));

  pixel_hit_mask u_hit_mask (
    .r_i            (row_w),
    .c_i            (col_w),
    .stride_i       (stride),
    .kernel_width_i (kernel_width),
    .mask_o         (hit_mask_w),
    .kx_o           (hit_kx_w),
    .ky_o           (hit_ky_w)
  );

`ifdef INDEX_ENCODER_CHECK_EN
  localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W+1)'(NK * NK);
  localparam logic [KC_W:0]  KW_LIMIT  = (KC_W+1)'(K);

  assign illegal_w = ({1'b0, in_index} >= IDX_LIMIT) || (stride == '0) ||
                     (kernel_width == '0) || ({1'b0, kernel_width} > KW_LIMIT);
`else
  assign illegal_w = 1'b0;
`endif

  // Lowest-set-bit priority encoder over the remaining hits.
  always_comb begin
    sel_pix = '0;
    found   = 1'b0;
    for (int unsigned p = 0; p < NPIX; p++) begin
      if (mask_q[p] && !found) begin
        sel_pix = PIX_W'(p);
        found   = 1'b1;
      end
    end
  end

  assign mask_d = mask_q & (mask_q - NPIX'(1));
  assign last_w = (mask_d == '0);
  assign emit_w = (state_q == EMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      kx_q    <= '0;
      ky_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= EMIT;
            mask_q  <= illegal_w ? '0 : hit_mask_w;
            kx_q    <= hit_kx_w;
            ky_q    <= hit_ky_w;
            err_q   <= illegal_w;
          end
        end
        EMIT: begin
          if (out_ready) begin
            mask_q <= mask_d;
            if (last_w) begin
              state_q <= IDLE;
              err_q   <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = emit_w;
  assign out_hit   = emit_w && found;
  assign out_last  = emit_w && last_w;
  assign out_pixel = (emit_w && found) ? sel_pix : '0;
  assign out_kidx  = (emit_w && found) ? kidx_of(kx_q[sel_pix], ky_q[sel_pix]) : '0;

`ifdef INDEX_ENCODER_CHECK_EN
  assign out_err = emit_w && err_q;
`else
  assign out_err = 1'b0 & err_q;
`endif

endmodule

// File: tb/tb_conv_index_encoder.sv
// Scoreboard bench for conv_index_encoder: directed requests push hand-computed beats,
// a negedge monitor pops and compares every handshaken beat and checks stall stability.
module tb_conv_index_encoder;
  import conv_index_pkg::*;

  typedef struct packed {
    logic [PIX_W-1:0]  pix;
    logic [KIDX_W-1:0] kidx;
    logic              hit;
    logic              last;
    logic              err;
  } beat_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [IDX_W-1:0]  in_index;
  logic [KC_W-1:0]   stride;
  logic [KC_W-1:0]   kernel_width;
  logic              out_valid;
  logic              out_ready;
  logic [PIX_W-1:0]  out_pixel;
  logic [KIDX_W-1:0] out_kidx;
  logic              out_hit;
  logic              out_last;
  logic              out_err;

  beat_t exp_q[$];
  int    n_cmp;
  int    n_fail;
  bit    toggle_ready;
  bit    check_ready_next;

  conv_index_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_index     (in_index),
    .stride       (stride),
    .kernel_width (kernel_width),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pixel    (out_pixel),
    .out_kidx     (out_kidx),
    .out_hit      (out_hit),
    .out_last     (out_last),
    .out_err      (out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string name, input beat_t act, input beat_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pix=%0d kidx=%0d hit=%0b last=%0b err=%0b required pix=%0d kidx=%0d hit=%0b last=%0b err=%0b",
               name, act.pix, act.kidx, act.hit, act.last, act.err,
               exp.pix, exp.kidx, exp.hit, exp.last, exp.err);
    end
  endtask

  function automatic void push(input int pix, input int kidx, input bit hit, input bit last,
                               input bit err);
    beat_t b;
    b.pix  = PIX_W'(pix);
    b.kidx = KIDX_W'(kidx);
    b.hit  = hit;
    b.last = last;
    b.err  = err;
    exp_q.push_back(b);
  endfunction

  // out_ready driver: held at 1, or toggled every cycle when requested.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_ready) out_ready = ~out_ready;
      else              out_ready = 1'b1;
    end
  end

  // Monitor: compares every handshaken beat against the scoreboard head.
  initial begin
    beat_t act;
    beat_t held;
    bit    held_v;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (check_ready_next) begin
          chk("in_ready_after_last", 32'(in_ready), 32'd1);
          check_ready_next = 1'b0;
        end
        if (out_valid) begin
          act = '{pix: out_pixel, kidx: out_kidx, hit: out_hit, last: out_last, err: out_err};
          if (held_v) chk_beat("stall_hold", act, held);
          chk("in_ready_during_emit", 32'(in_ready), 32'd0);
          if (out_ready) begin
            held_v = 1'b0;
            if (exp_q.size() == 0) begin
              chk_beat("unexpected_beat", act, '0);
              if (act == '0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got extra beat required none");
              end
            end else begin
              beat_t e;
              e = exp_q.pop_front();
              chk_beat("beat", act, e);
              if (e.last) check_ready_next = 1'b1;
            end
          end else begin
            held   = act;
            held_v = 1'b1;
          end
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  task automatic send(input int idx, input int s, input int kw);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_wait", 32'(n < 200), 32'd1);
    in_valid     = 1'b1;
    in_index     = IDX_W'(idx);
    stride       = KC_W'(s);
    kernel_width = KC_W'(kw);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_bound", 32'(n < 500), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    n_cmp            = 0;
    n_fail           = 0;
    toggle_ready     = 1'b0;
    check_ready_next = 1'b0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_index     = '0;
    stride       = '0;
    kernel_width = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", 32'({out_pixel, out_kidx, out_hit, out_last, out_err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // r2,c2 stride 2: every pixel covers it.
    push(0, 8, 1, 0, 0); push(1, 6, 1, 0, 0); push(2, 2, 1, 0, 0); push(3, 0, 1, 1, 0);
    send(14, 2, 3);
    drain();

    push(0, 0, 1, 1, 0);
    send(0, 2, 3);
    drain();

    // Corner r5,c5 with stride 1: out of reach of every pixel.
    push(0, 0, 0, 1, 0);
    send(35, 1, 3);
    drain();

    toggle_ready = 1'b1;
    push(3, 8, 1, 1, 0);
    send(35, 3, 3);
    drain();
    toggle_ready = 1'b0;
    repeat (2) @(negedge clk);

    // r1,c1 stride 1 with a 2x2 kernel window.
    push(0, 4, 1, 0, 0); push(1, 3, 1, 0, 0); push(2, 1, 1, 0, 0); push(3, 0, 1, 1, 0);
    send(7, 1, 2);
    drain();

    // Reset during the second beat: only the first beat is expected.
    push(0, 8, 1, 0, 0);
    send(14, 2, 3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_outputs", 32'({out_pixel, out_kidx, out_hit, out_last, out_err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_out_valid", 32'(out_valid), 32'd0);
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    chk("postrst_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    push(0, 0, 1, 1, 0);
    send(0, 2, 3);
    drain();

`ifdef INDEX_ENCODER_CHECK_EN
    push(0, 0, 0, 1, 1);
    send(36, 2, 3);
    drain();
    push(0, 0, 0, 1, 1);
    send(14, 0, 3);
    drain();
`else
    // Unchecked: index 36 is r6,c0, beyond every pixel's window.
    push(0, 0, 0, 1, 0);
    send(36, 2, 3);
    drain();
    // Unchecked stride 0: all pixels see offset (2,2).
    push(0, 8, 1, 0, 0); push(1, 8, 1, 0, 0); push(2, 8, 1, 0, 0); push(3, 8, 1, 1, 0);
    send(14, 0, 3);
    drain();
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
